// File: rtl/mips_bus_arbiter.sv
// Two-master / one-slave Avalon-style bus arbiter for the MIPS memory bus.
// Grants whole transfers, forwards the owner combinationally, flags long slave stalls.
//
// state | meaning
// IDLE  | arbitration cycle, no slave request, both masters stalled
// GNT0  | master 0 owns the slave, signals forwarded
// GNT1  | master 1 owns the slave, signals forwarded
module mips_bus_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1,
   parameter int STALL_LIMIT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [3:0]  m0_byteenable,
   input  logic [31:0] m0_writedata,
   output logic [31:0] m0_readdata,
   output logic        m0_waitrequest,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [3:0]  m1_byteenable,
   input  logic [31:0] m1_writedata,
   output logic [31:0] m1_readdata,
   output logic        m1_waitrequest,
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [3:0]  s_byteenable,
   output logic [31:0] s_writedata,
   input  logic [31:0] s_readdata,
   input  logic        s_waitrequest,
   output logic [1:0]  grant,
   output logic        stall_err
);

   localparam int CW = $clog2(STALL_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic          ptr_q, ptr_d;             // 0 = m0 has priority, 1 = m1
   logic [CW-1:0] stall_cnt_q, stall_cnt_d;
   logic          stall_err_q, stall_err_d;
   logic          m0_req, m1_req, cur_req;

   assign m0_req  = m0_read | m0_write;
   assign m1_req  = m1_read | m1_write;
   assign cur_req = (state_q == GNT1) ? m1_req : m0_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      stall_cnt_d = stall_cnt_q;
      stall_err_d = stall_err_q;
      case (state_q)
         IDLE: begin
            stall_cnt_d = '0;
            if (m0_req && (!m1_req || !ROUND_ROBIN || !ptr_q))
               state_d = GNT0;
            else if (m1_req)
               state_d = GNT1;
         end
         GNT0, GNT1: begin
            if (!cur_req) begin
               state_d = IDLE;
            end else if (!s_waitrequest) begin
               state_d     = IDLE;
               stall_cnt_d = '0;
               if (ROUND_ROBIN)
                  ptr_d = (state_q == GNT0);
            end
            // The grant is never aborted; the error is only reported.
            if (s_waitrequest && (stall_cnt_q != LIMIT)) begin
               stall_cnt_d = stall_cnt_q + 1'b1;
               if (stall_cnt_q == LIMIT - 1'b1)
                  stall_err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_address      = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_byteenable   = '0;
      s_writedata    = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      case (state_q)
         GNT0: begin
            s_address      = m0_address;
            s_read         = m0_read;
            s_write        = m0_write;
            s_byteenable   = m0_byteenable;
            s_writedata    = m0_writedata;
            m0_waitrequest = s_waitrequest;
         end
         GNT1: begin
            s_address      = m1_address;
            s_read         = m1_read;
            s_write        = m1_write;
            s_byteenable   = m1_byteenable;
            s_writedata    = m1_writedata;
            m1_waitrequest = s_waitrequest;
         end
         default: ;
      endcase
   end

   assign m0_readdata = s_readdata;
   assign m1_readdata = s_readdata;
   assign grant       = state_q;
   assign stall_err   = stall_err_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: round-robin instance with a stalling memory
// model, plus a fixed-priority instance on an always-ready slave.
module tb_mips_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata, s_readdata;
   logic        m0_waitrequest, m1_waitrequest, s_read, s_write, s_waitrequest;
   logic [3:0]  s_byteenable;
   logic [1:0]  grant;
   logic        stall_err;

   logic [31:0] fp_m0_readdata, fp_m1_readdata, fp_s_address, fp_s_writedata;
   logic        fp_m0_waitrequest, fp_m1_waitrequest, fp_s_read, fp_s_write;
   logic [3:0]  fp_s_byteenable;
   logic [1:0]  fp_grant;
   logic        fp_stall_err;
   logic        fp_s_waitrequest = 1'b0;
   logic [31:0] fp_s_readdata = 32'h0;

   int n_err = 0;
   int n_chk = 0;

   logic [31:0] mem [0:2047];
   int          num_stalls = 0;
   int          scnt = 0;

   always #5 clk = ~clk;

   mips_bus_arbiter #(.ROUND_ROBIN(1'b1), .STALL_LIMIT(6)) u_dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_byteenable(s_byteenable), .s_writedata(s_writedata),
      .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
      .grant(grant), .stall_err(stall_err)
   );

   mips_bus_arbiter #(.ROUND_ROBIN(1'b0), .STALL_LIMIT(1024)) u_fp (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_readdata(fp_m0_readdata), .m0_waitrequest(fp_m0_waitrequest),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_readdata(fp_m1_readdata), .m1_waitrequest(fp_m1_waitrequest),
      .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
      .s_byteenable(fp_s_byteenable), .s_writedata(fp_s_writedata),
      .s_readdata(fp_s_readdata), .s_waitrequest(fp_s_waitrequest),
      .grant(fp_grant), .stall_err(fp_stall_err)
   );

   // Memory slave: stalls num_stalls cycles per transfer, then completes.
   assign s_waitrequest = (s_read | s_write) && (scnt < num_stalls);
   assign s_readdata    = mem[s_address[12:2]];

   always @(posedge clk) begin
      if (!(s_read | s_write)) begin
         scnt <= 0;
      end else if (s_waitrequest) begin
         scnt <= scnt + 1;
      end else begin
         scnt <= 0;
         if (s_write)
            for (int b = 0; b < 4; b++)
               if (s_byteenable[b]) mem[s_address[12:2]][8*b +: 8] <= s_writedata[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_xfer(input int who, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          output int cycles, output logic [31:0] rd, output bit stable);
      bit         done;
      logic [1:0] mine;
      done   = 1'b0;
      cycles = 0;
      rd     = '0;
      stable = 1'b1;
      mine   = (who == 0) ? 2'b01 : 2'b10;
      if (who == 0) begin
         m0_address = addr; m0_byteenable = be; m0_writedata = wd;
         m0_read = !wr; m0_write = wr;
      end else begin
         m1_address = addr; m1_byteenable = be; m1_writedata = wd;
         m1_read = !wr; m1_write = wr;
      end
      for (int k = 0; k < 60 && !done; k++) begin
         tick();
         cycles++;
         if (grant == mine) begin
            if (s_address !== addr || s_read !== !wr || s_write !== wr || s_byteenable !== be)
               stable = 1'b0;
            if (((who == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
               rd = (who == 0) ? m0_readdata : m1_readdata;
               tick();
               cycles++;
               done = 1'b1;
            end
         end
      end
      if (who == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
      else          begin m1_read = 1'b0; m1_write = 1'b0; end
      if (!done) check("xfer_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          cyc;
      logic [31:0] rd;
      bit          st;
      int          nrr, nfp;
      logic [1:0]  rr_exp [4];

      for (int i = 0; i < 2048; i++) mem[i] = 32'hC0DE_0000 | i;
      m0_address = 32'h100; m0_read = 1'b1; m0_write = 1'b0;
      m0_byteenable = 4'hF; m0_writedata = '0;
      m1_address = '0; m1_read = 1'b0; m1_write = 1'b0;
      m1_byteenable = 4'hF; m1_writedata = '0;
      reset = 1'b1;

      // Reset with a pending m0 read, then first transfer.
      #2;
      check("rst_s_read", s_read, 1'b0);
      check("rst_grant", grant, 2'b00);
      check("rst_m0_wait", m0_waitrequest, 1'b1);
      check("rst_stall_err", stall_err, 1'b0);
      check("rst_s_address", s_address, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("idle_grant", grant, 2'b00);
      check("idle_m0_wait", m0_waitrequest, 1'b1);
      tick();
      check("first_grant", grant, 2'b01);
      check("first_s_addr", s_address, 32'h100);
      check("first_m0_wait", m0_waitrequest, 1'b0);
      check("first_rdata", m0_readdata, 32'hC0DE_0040);
      tick();
      check("first_done", grant, 2'b00);
      m0_read = 1'b0;

      // Round robin (pointer now at m1) and fixed priority side by side.
      rr_exp[0] = 2'b10; rr_exp[1] = 2'b01; rr_exp[2] = 2'b10; rr_exp[3] = 2'b01;
      nrr = 0; nfp = 0;
      m0_read = 1'b1; m1_read = 1'b1;
      m0_address = 32'h104; m1_address = 32'h108;
      for (int k = 0; k < 40 && nrr < 4; k++) begin
         tick();
         if (fp_grant != 2'b00) begin
            check("fp_grant", fp_grant, 2'b01);
            check("fp_m1_wait", fp_m1_waitrequest, 1'b1);
            nfp++;
         end
         if (grant != 2'b00 && !s_waitrequest) begin
            check($sformatf("rr_grant%0d", nrr), grant, rr_exp[nrr]);
            nrr++;
            if (nrr == 4) begin
               tick();
               m0_read = 1'b0; m1_read = 1'b0;
            end
         end
      end
      check("rr_count", nrr, 4);
      check("fp_count", nfp, 4);

      // Partial-lane write by m1, read back by m0.
      do_xfer(1, 1'b1, 32'h1000, 4'b0011, 32'hDEAD_BEEF, cyc, rd, st);
      check("wr_cycles", cyc, 2);
      check("wr_stable", st, 1'b1);
      do_xfer(0, 1'b0, 32'h1000, 4'hF, 32'h0, cyc, rd, st);
      check("rb_cycles", cyc, 2);
      check("rb_data", rd, 32'hC0DE_BEEF);

      // Five stalls, below the limit of six.
      num_stalls = 5;
      do_xfer(0, 1'b0, 32'h200, 4'hF, 32'h0, cyc, rd, st);
      check("stall5_cycles", cyc, 7);
      check("stall5_stable", st, 1'b1);
      check("stall5_rdata", rd, 32'hC0DE_0080);
      check("stall5_err", stall_err, 1'b0);

      // Abandon by m1 leaves the pointer at m1.
      num_stalls = 20;
      m1_address = 32'h300; m1_read = 1'b1;
      tick();
      check("ab_grant", grant, 2'b10);
      check("ab_m0_wait", m0_waitrequest, 1'b1);
      tick();
      tick();
      m1_read = 1'b0;
      #1 check("ab_s_read", s_read, 1'b0);
      tick();
      check("ab_idle", grant, 2'b00);
      num_stalls = 0;
      m0_address = 32'h100; m0_read = 1'b1; m1_read = 1'b1;
      tick();
      check("ab_ptr_kept", grant, 2'b10);
      check("ab_m1_wait", m1_waitrequest, 1'b0);
      tick();
      m1_read = 1'b0;
      check("ab_m1_done", grant, 2'b00);
      tick();
      check("ab_m0_next", grant, 2'b01);
      check("ab_m0_rdata", m0_readdata, 32'hC0DE_0040);
      tick();
      m0_read = 1'b0;
      check("ab_m0_done", grant, 2'b00);

      // Six stalls hit the limit on the sixth stalled edge.
      num_stalls = 6;
      m0_address = 32'h200; m0_read = 1'b1;
      tick();
      check("err_grant", grant, 2'b01);
      repeat (5) tick();
      check("err_before", stall_err, 1'b0);
      tick();
      check("err_set", stall_err, 1'b1);
      check("err_xfer_alive", m0_waitrequest, 1'b0);
      tick();
      m0_read = 1'b0;
      check("err_done", grant, 2'b00);
      check("err_sticky", stall_err, 1'b1);

      // Reset in the middle of a stalled m0 transfer.
      num_stalls = 20;
      m0_address = 32'h100; m0_read = 1'b1;
      tick();
      check("mr_grant", grant, 2'b01);
      tick();
      reset = 1'b1;
      #1;
      check("mr_s_read", s_read, 1'b0);
      check("mr_grant0", grant, 2'b00);
      check("mr_m0_wait", m0_waitrequest, 1'b1);
      check("mr_err_clr", stall_err, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;
      num_stalls = 2;
      do_xfer(0, 1'b0, 32'h100, 4'hF, 32'h0, cyc, rd, st);
      check("mr_cycles", cyc, 4);
      check("mr_rdata", rd, 32'hC0DE_0040);
      check("mr_stable", st, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
